beat_sequencer: RTL and testbench

//  Receiving end of the six-phase one-hot beat bus t0..t5 driven by the CPU beat generator.
//  - Checks that the bus is one-hot and advances t0->t1->...->t5->t0 without skipping.
//  - Locks to the sequence and decodes each accepted beat into registered micro-op strobes.
//  - Counts completed machine cycles.
//  - Flags protocol faults to the control unit.

---
 rtl/beat_sequencer.sv | 135 +++++++++++++
 tb/tb_beat_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_sequencer.sv
// Beat sequencer: locks to the six-phase one-hot beat bus, decodes accepted
// beats into registered micro-op strobes, counts machine cycles, and flags
// protocol faults.
module beat_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter bit          AUTO_RESYNC = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t0,
  input  logic             t1,
  input  logic             t2,
  input  logic             t3,
  input  logic             t4,
  input  logic             t5,
  input  logic             resync,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       err_code,
  output logic [2:0]       beat_idx,
  output logic             fetch_en,
  output logic             pc_inc,
  output logic             ir_load,
  output logic             exec_en,
  output logic             wb_en,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int unsigned NB    = 6;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_NOT_OH = 2'b01;
  localparam logic [1:0] ERR_ORDER  = 2'b10;

  state_t             state_q, state_nxt;
  logic [IDX_W-1:0]   exp_q, exp_nxt;
  logic [NB-1:0]      bus_c;
  logic               one_hot_c;
  logic               accept_c;
  logic [IDX_W-1:0]   acc_idx_c;
  logic [1:0]         err_nxt;

  // Gather the beat bus and classify it.
  assign bus_c     = {t5, t4, t3, t2, t1, t0};
  assign one_hot_c = (bus_c != '0) && ((bus_c & (bus_c - NB'(1))) == '0);

  // Next state, expected beat, acceptance and error code.
  always_comb begin
    state_nxt = state_q;
    exp_nxt   = exp_q;
    accept_c  = 1'b0;
    acc_idx_c = exp_q;
    err_nxt   = err_code;
    if (resync) begin
      state_nxt = ST_SYNC;
      err_nxt   = ERR_NONE;
    end else begin
      case (state_q)
        ST_SYNC: begin
          if (bus_c == NB'(1)) begin
            accept_c  = 1'b1;
            acc_idx_c = '0;
            exp_nxt   = IDX_W'(1);
            state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus_c == (NB'(1) << exp_q)) begin
            accept_c = 1'b1;
            exp_nxt  = (exp_q == IDX_W'(NB - 1)) ? '0 : exp_q + IDX_W'(1);
          end else begin
            state_nxt = ST_FAULT;
            err_nxt   = one_hot_c ? ERR_ORDER : ERR_NOT_OH;
          end
        end
        ST_FAULT: begin
          if (AUTO_RESYNC) begin
            state_nxt = ST_SYNC;
            err_nxt   = ERR_NONE;
          end
        end
        default: begin
          state_nxt = ST_SYNC;
          err_nxt   = ERR_NONE;
        end
      endcase
    end
  end

  // State, expected beat and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SYNC;
      exp_q      <= '0;
      locked     <= 1'b0;
      fault      <= 1'b0;
      err_code   <= ERR_NONE;
      beat_idx   <= '0;
      fetch_en   <= 1'b0;
      pc_inc     <= 1'b0;
      ir_load    <= 1'b0;
      exec_en    <= 1'b0;
      wb_en      <= 1'b0;
      cycle_done <= 1'b0;
      cycle_cnt  <= '0;
    end else begin
      state_q    <= state_nxt;
      exp_q      <= exp_nxt;
      locked     <= (state_nxt == ST_RUN);
      fault      <= (state_nxt == ST_FAULT);
      err_code   <= err_nxt;
      fetch_en   <= accept_c && (acc_idx_c == IDX_W'(0));
      pc_inc     <= accept_c && (acc_idx_c == IDX_W'(1));
      ir_load    <= accept_c && (acc_idx_c == IDX_W'(2));
      exec_en    <= accept_c && ((acc_idx_c == IDX_W'(3)) || (acc_idx_c == IDX_W'(4)));
      wb_en      <= accept_c && (acc_idx_c == IDX_W'(5));
      cycle_done <= accept_c && (acc_idx_c == IDX_W'(5));
      if (accept_c) begin
        beat_idx <= acc_idx_c;
      end
      if (accept_c && (acc_idx_c == IDX_W'(5))) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer: two instances (CNT_W=4 held-fault, CNT_W=16
// auto-resync) share one stimulus and are checked every cycle against a
// behavioural model, plus directed literal checks.
module tb_beat_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic t0 = 1'b0, t1 = 1'b0, t2 = 1'b0, t3 = 1'b0, t4 = 1'b0, t5 = 1'b0;
  logic resync = 1'b0;

  logic       locked_a, fault_a, fetch_a, pc_a, ir_a, exec_a, wb_a, done_a;
  logic [1:0] err_a;
  logic [2:0] idx_a;
  logic [3:0] cnt_a;

  logic       locked_b, fault_b, fetch_b, pc_b, ir_b, exec_b, wb_b, done_b;
  logic [1:0] err_b;
  logic [2:0] idx_b;
  logic [15:0] cnt_b;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  beat_sequencer #(.CNT_W(4), .AUTO_RESYNC(1'b0)) dut_a (
    .clk(clk), .rst(rst), .t0(t0), .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t5(t5),
    .resync(resync), .locked(locked_a), .fault(fault_a), .err_code(err_a),
    .beat_idx(idx_a), .fetch_en(fetch_a), .pc_inc(pc_a), .ir_load(ir_a),
    .exec_en(exec_a), .wb_en(wb_a), .cycle_done(done_a), .cycle_cnt(cnt_a)
  );

  beat_sequencer #(.CNT_W(16), .AUTO_RESYNC(1'b1)) dut_b (
    .clk(clk), .rst(rst), .t0(t0), .t1(t1), .t2(t2), .t3(t3), .t4(t4), .t5(t5),
    .resync(resync), .locked(locked_b), .fault(fault_b), .err_code(err_b),
    .beat_idx(idx_b), .fetch_en(fetch_b), .pc_inc(pc_b), .ir_load(ir_b),
    .exec_en(exec_b), .wb_en(wb_b), .cycle_done(done_b), .cycle_cnt(cnt_b)
  );

  // Model state: mode 0=sync 1=run 2=fault; nb = next beat; beat = beat accepted this step or -1.
  typedef struct {
    int mode;
    int nb;
    int idx;
    int cnt;
    int err;
    int beat;
  } mdl_t;

  mdl_t ma = '{0, 0, 0, 0, 0, -1};
  mdl_t mb = '{0, 0, 0, 0, 0, -1};

  function automatic mdl_t mstep(mdl_t s, bit auto_rs, int cw, logic [5:0] b, logic r, logic rs);
    mdl_t n;
    n = s;
    n.beat = -1;
    if (r) begin
      n.mode = 0; n.nb = 0; n.idx = 0; n.cnt = 0; n.err = 0;
    end else if (rs) begin
      n.mode = 0; n.err = 0;
    end else if (s.mode == 0) begin
      if (b == 6'b000001) begin
        n.mode = 1; n.beat = 0; n.idx = 0; n.nb = 1;
      end
    end else if (s.mode == 1) begin
      if ($countones(b) == 1 && b[s.nb] == 1'b1) begin
        n.beat = s.nb;
        n.idx  = s.nb;
        n.nb   = (s.nb + 1) % 6;
        if (s.nb == 5) n.cnt = (s.cnt + 1) % (1 << cw);
      end else begin
        n.mode = 2;
        n.err  = ($countones(b) == 1) ? 2 : 1;
      end
    end else if (auto_rs) begin
      n.mode = 0; n.err = 0;
    end
    return n;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input mdl_t e, input logic lk, input logic fl,
                     input logic [1:0] ec, input logic [2:0] bi, input logic fe, input logic pi,
                     input logic il, input logic ee, input logic we, input logic cd,
                     input logic [15:0] cc);
    check({tag, ".locked"},     32'(lk), 32'(e.mode == 1));
    check({tag, ".fault"},      32'(fl), 32'(e.mode == 2));
    check({tag, ".err_code"},   32'(ec), 32'(e.err));
    check({tag, ".beat_idx"},   32'(bi), 32'(e.idx));
    check({tag, ".fetch_en"},   32'(fe), 32'(e.beat == 0));
    check({tag, ".pc_inc"},     32'(pi), 32'(e.beat == 1));
    check({tag, ".ir_load"},    32'(il), 32'(e.beat == 2));
    check({tag, ".exec_en"},    32'(ee), 32'(e.beat == 3 || e.beat == 4));
    check({tag, ".wb_en"},      32'(we), 32'(e.beat == 5));
    check({tag, ".cycle_done"}, 32'(cd), 32'(e.beat == 5));
    check({tag, ".cycle_cnt"},  32'(cc), 32'(e.cnt));
  endtask

  // Advance the model on every sampling edge.
  always @(posedge clk) begin
    ma = mstep(ma, 1'b0, 4,  {t5, t4, t3, t2, t1, t0}, rst, resync);
    mb = mstep(mb, 1'b1, 16, {t5, t4, t3, t2, t1, t0}, rst, resync);
  end

  // Compare both instances against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("a", ma, locked_a, fault_a, err_a, idx_a, fetch_a, pc_a, ir_a, exec_a, wb_a, done_a, {12'b0, cnt_a});
      cmp("b", mb, locked_b, fault_b, err_b, idx_b, fetch_b, pc_b, ir_b, exec_b, wb_b, done_b, cnt_b);
    end
  end

  task automatic drive(input logic [5:0] b, input logic rs, input logic r);
    {t5, t4, t3, t2, t1, t0} = b;
    resync = rs;
    rst    = r;
    @(negedge clk);
  endtask

  function automatic logic [5:0] oh(input int i);
    logic [5:0] v;
    v = 6'b000001;
    return v << i;
  endfunction

  int dones;

  initial begin
    // Reset
    drive(6'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    check("rst.locked", 32'(locked_a), 32'd0);
    check("rst.cnt",    32'(cnt_a),    32'd0);

    // Two clean machine cycles
    dones = 0;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 6; i++) begin
        drive(oh(i), 1'b0, 1'b0);
        dones += int'(done_a);
        if (c == 0 && i == 0) begin
          check("t1.locked_after_t0", 32'(locked_a), 32'd1);
          check("t1.fetch_after_t0",  32'(fetch_a),  32'd1);
        end
        if (i == 3 || i == 4) check("t1.exec", 32'(exec_a), 32'd1);
      end
    end
    check("t1.cycle_done_pulses", 32'(dones), 32'd2);
    check("t1.cycle_cnt",         32'(cnt_a), 32'd2);

    // Zero bus after t2
    for (int i = 0; i < 3; i++) drive(oh(i), 1'b0, 1'b0);
    drive(6'b0, 1'b0, 1'b0);
    check("t2.fault",    32'(fault_a),  32'd1);
    check("t2.err",      32'(err_a),    32'd1);
    check("t2.locked",   32'(locked_a), 32'd0);
    check("t2.beat_idx", 32'(idx_a),    32'd2);

    // Out-of-order t3 after t1, held fault, then resync and relock
    drive(6'b0, 1'b1, 1'b0);
    check("t3.resync_clears", 32'(fault_a), 32'd0);
    drive(oh(0), 1'b0, 1'b0);
    drive(oh(1), 1'b0, 1'b0);
    drive(oh(3), 1'b0, 1'b0);
    check("t3.err_order", 32'(err_a), 32'd2);
    for (int i = 0; i < 10; i++) begin
      drive(oh(i % 6), 1'b0, 1'b0);
      check("t3.fault_held", 32'(fault_a), 32'd1);
    end
    drive(6'b0, 1'b1, 1'b0);
    check("t3.unfault", 32'(fault_a), 32'd0);
    drive(oh(1), 1'b0, 1'b0);
    check("t3.no_lock_on_t1", 32'(locked_a), 32'd0);
    drive(oh(0), 1'b0, 1'b0);
    check("t3.relock", 32'(locked_a), 32'd1);

    // Counter wrap with CNT_W=4
    drive(6'b0, 1'b0, 1'b1);
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < 6; i++) begin
        drive(oh(i), 1'b0, 1'b0);
        check("t4.no_fault", 32'(fault_a), 32'd0);
      end
      if (c == 14) check("t4.cnt15", 32'(cnt_a), 32'd15);
    end
    check("t4.cnt_wrap", 32'(cnt_a), 32'd0);
    check("t4.cnt_b16",  32'(cnt_b), 32'd16);

    // Reset mid-cycle, then resync coincident with a mismatch
    for (int i = 0; i < 3; i++) drive(oh(i), 1'b0, 1'b0);
    drive(oh(3), 1'b0, 1'b1);
    check("t5.locked", 32'(locked_a), 32'd0);
    check("t5.idx",    32'(idx_a),    32'd0);
    check("t5.cnt",    32'(cnt_a),    32'd0);
    drive(oh(4), 1'b0, 1'b0);
    check("t5.no_relock", 32'(locked_a), 32'd0);
    drive(oh(0), 1'b0, 1'b0);
    check("t5.relock", 32'(locked_a), 32'd1);
    drive(oh(1), 1'b0, 1'b0);
    drive(oh(3), 1'b1, 1'b0);
    check("t5.resync_beats_fault", 32'(fault_a), 32'd0);
    check("t5.resync_unlocks",     32'(locked_a), 32'd0);

    // Randomized traffic
    begin
      int g;
      int r;
      logic [5:0] b;
      logic rs;
      logic rr;
      g = 0;
      for (int n = 0; n < 4000; n++) begin
        r  = int'($urandom_range(0, 999));
        rs = 1'b0;
        rr = 1'b0;
        if (r < 30) begin
          b = 6'($urandom);
        end else if (r < 60) begin
          b = oh(int'($urandom_range(0, 5)));
        end else begin
          b = oh(g);
          g = (g + 1) % 6;
          if (r < 80) rs = 1'b1;
          else if (r < 84) rr = 1'b1;
        end
        drive(b, rs, rr);
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
